// File: rtl/note_recorder_pkg.sv
// Shared song-entry encoding and constants for the note recorder and the tone player.
package note_recorder_pkg;

    localparam int unsigned OCTAVE_BITS    = 3;
    localparam int unsigned NOTE_BITS      = 3;
    localparam int unsigned LENGTH_BITS    = 3;
    localparam int unsigned FULL_NOTE_BITS = 4;
    localparam int unsigned NUM_KEYS       = 7;
    localparam int unsigned SEG_W          = 32;
    localparam int unsigned DATA_W         = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

    localparam logic [NOTE_BITS-1:0]   NOTE_REST  = NOTE_BITS'(7);
    localparam logic [LENGTH_BITS-1:0] MAX_LENGTH = LENGTH_BITS'(6);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_QUANT,
        ST_COMMIT
    } rec_state_e;

    typedef struct packed {
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
    } song_entry_t;

    // Lowest set key wins; no key pressed encodes as a rest.
    function automatic logic [NOTE_BITS-1:0] active_note(input logic [NUM_KEYS-1:0] keys);
        logic [NOTE_BITS-1:0] n;
        n = NOTE_REST;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (keys[i]) begin
                n = NOTE_BITS'(i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/note_quantizer.sv
// Walks length codes L = 0..MAX_LENGTH, one per cycle, to find the first L with (T >> L) <= D.
module note_quantizer
    import note_recorder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   active,
    input  logic [SEG_W-1:0]       dur,
    input  logic [SEG_W-1:0]       whole,
    output logic                   done_c,
    output logic                   discard_c,
    output logic [LENGTH_BITS-1:0] len_c
);

    logic [LENGTH_BITS-1:0] len_q;
    logic [LENGTH_BITS-1:0] len_d;
    logic                   hit_c;

    // One candidate per cycle; running out of codes means the segment is too short to keep.
    always_comb begin
        hit_c     = (whole >> len_q) <= dur;
        done_c    = active && (hit_c || (len_q == MAX_LENGTH));
        discard_c = done_c && !hit_c;
        len_c     = len_q;
        len_d     = len_q;
        if (start) begin
            len_d = '0;
        end else if (active && !done_c) begin
            len_d = LENGTH_BITS'(len_q + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Records live key play as quantized {octave, note, length} entries into the song RAM write port.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_KEYS-1:0]       key,
    input  logic [OCTAVE_BITS-1:0]    octave,
    input  logic [FULL_NOTE_BITS-1:0] full_note,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [ADDR_W:0]           count,
    output logic                      full,
    output logic                      busy
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    rec_state_e             state_q, state_d;
    logic [NUM_KEYS-1:0]    key_s1_q, key_s1_d;
    logic [NUM_KEYS-1:0]    key_s2_q, key_s2_d;
    logic                   en_prev_q, en_prev_d;
    logic [SEG_W-1:0]       t_q, t_d;
    logic [SEG_W-1:0]       seg_cnt_q, seg_cnt_d;
    logic [NOTE_BITS-1:0]   seg_note_q, seg_note_d;
    logic [OCTAVE_BITS-1:0] seg_oct_q, seg_oct_d;
    logic [SEG_W-1:0]       dur_q, dur_d;
    logic [NOTE_BITS-1:0]   pend_note_q, pend_note_d;
    logic [OCTAVE_BITS-1:0] pend_oct_q, pend_oct_d;
    logic                   exit_q, exit_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    song_entry_t            wr_data_q, wr_data_d;
    logic                   full_q, full_d;
    logic                   busy_q, busy_d;

    logic [NOTE_BITS-1:0]   note_cur_c;
    logic                   en_rise_c;
    logic [63:0]            prod_c;
    logic [SEG_W-1:0]       t_new_c;
    logic                   q_start_c;
    logic                   q_done_c;
    logic                   q_discard_c;
    logic [LENGTH_BITS-1:0] q_len_c;

    note_quantizer u_quant (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (q_start_c),
        .active    (state_q == ST_QUANT),
        .dur       (dur_q),
        .whole     (t_q),
        .done_c    (q_done_c),
        .discard_c (q_discard_c),
        .len_c     (q_len_c)
    );

    always_comb begin
        key_s1_d    = key;
        key_s2_d    = key_s1_q;
        en_prev_d   = en;
        state_d     = state_q;
        t_d         = t_q;
        seg_cnt_d   = seg_cnt_q;
        seg_note_d  = seg_note_q;
        seg_oct_d   = seg_oct_q;
        dur_d       = dur_q;
        pend_note_d = pend_note_q;
        pend_oct_d  = pend_oct_q;
        exit_d      = exit_q;
        count_d     = count_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        q_start_c   = 1'b0;

        note_cur_c = active_note(key_s2_q);
        en_rise_c  = en && !en_prev_q;
        prod_c     = 64'(full_note) * 64'(CLK_HZ);
        t_new_c    = (prod_c[63:32] != '0) ? '1 : prod_c[31:0];

        // The current segment keeps aging while an earlier one is being quantized.
        if ((state_q == ST_RUN || state_q == ST_QUANT || state_q == ST_COMMIT) && (seg_cnt_q != '1)) begin
            seg_cnt_d = SEG_W'(seg_cnt_q + 1'b1);
        end

        case (state_q)
            ST_IDLE: begin
                if (en_rise_c) begin
                    count_d = '0;
                    t_d     = t_new_c;
                    exit_d  = 1'b0;
                    if (t_new_c != '0) begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (note_cur_c != NOTE_REST) begin
                    seg_cnt_d  = SEG_W'(1);
                    seg_note_d = note_cur_c;
                    seg_oct_d  = octave;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // A held note is flushed on session end; a trailing rest is not.
                    if (seg_note_q != NOTE_REST) begin
                        dur_d       = seg_cnt_q;
                        pend_note_d = seg_note_q;
                        pend_oct_d  = seg_oct_q;
                        exit_d      = 1'b1;
                        q_start_c   = 1'b1;
                        state_d     = ST_QUANT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (note_cur_c != seg_note_q) begin
                    dur_d       = seg_cnt_q;
                    pend_note_d = seg_note_q;
                    pend_oct_d  = seg_oct_q;
                    seg_cnt_d   = SEG_W'(1);
                    seg_note_d  = note_cur_c;
                    seg_oct_d   = octave;
                    q_start_c   = 1'b1;
                    state_d     = ST_QUANT;
                end
            end
            ST_QUANT: begin
                if (q_done_c) begin
                    if (q_discard_c) begin
                        state_d = exit_q ? ST_IDLE : ST_RUN;
                    end else begin
                        state_d = ST_COMMIT;
                        if (count_q < DEPTH_C) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = count_q[ADDR_W-1:0];
                            wr_data_d = '{octave: pend_oct_q, note: pend_note_q, length: q_len_c};
                        end
                    end
                end
            end
            ST_COMMIT: begin
                if (wr_en_q) begin
                    count_d = (ADDR_W + 1)'(count_q + 1'b1);
                end
                state_d = exit_q ? ST_IDLE : ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_QUANT) || (state_d == ST_COMMIT);
        full_d = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            en_prev_q   <= 1'b0;
            t_q         <= '0;
            seg_cnt_q   <= '0;
            seg_note_q  <= '0;
            seg_oct_q   <= '0;
            dur_q       <= '0;
            pend_note_q <= '0;
            pend_oct_q  <= '0;
            exit_q      <= 1'b0;
            count_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            en_prev_q   <= en_prev_d;
            t_q         <= t_d;
            seg_cnt_q   <= seg_cnt_d;
            seg_note_q  <= seg_note_d;
            seg_oct_q   <= seg_oct_d;
            dur_q       <= dur_d;
            pend_note_q <= pend_note_d;
            pend_oct_q  <= pend_oct_d;
            exit_q      <= exit_d;
            count_q     <= count_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;
    assign full    = full_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed song scenarios plus random sessions against a segment-level model.
module tb_note_recorder;

    localparam int unsigned CLK_HZ   = 640;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 2;
    localparam int          SYNC_LAT = 2;
    localparam int          TAIL     = 20;

    typedef struct {
        int note;
        int oct;
        int dur;
    } seg_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [6:0] key = '0;
    logic [2:0] octave = '0;
    logic [3:0] full_note = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt = 0;
    int unsigned t_cur = 0;

    int got_addr_q[$];
    int got_data_q[$];
    int got_cyc_q[$];
    int exp_data_q[$];
    int exp_cyc_q[$];
    seg_t plan[$];

    note_recorder #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .key       (key),
        .octave    (octave),
        .full_note (full_note),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .count     (count),
        .full      (full),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            got_addr_q.push_back(int'(wr_addr));
            got_data_q.push_back(int'(wr_data));
            got_cyc_q.push_back(cyc_cnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int got_at(input int i);
        if (i < got_data_q.size()) return got_data_q[i];
        return -1;
    endfunction

    // Spec rule: first L with (T >> L) <= D; none up to 6 means the segment is dropped.
    function automatic int quant_len(input int unsigned t, input int unsigned d);
        for (int l = 0; l <= 6; l++) begin
            if ((t >> l) <= d) return l;
        end
        return -1;
    endfunction

    task automatic model_seg(input int note, input int oct, input int d, input int bcyc);
        int l;
        l = quant_len(t_cur, d);
        if (l >= 0 && exp_data_q.size() < int'(DEPTH)) begin
            exp_data_q.push_back((oct << 6) | (note << 3) | l);
            exp_cyc_q.push_back(bcyc + l + 2);
        end
    endtask

    task automatic clear_logs();
        got_addr_q.delete();
        got_data_q.delete();
        got_cyc_q.delete();
        exp_data_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic start_session(input int fn);
        clear_logs();
        key       = '0;
        full_note = 4'(fn);
        t_cur     = int'(fn) * CLK_HZ;
        cyc(3);
        en = 1'b1;
        cyc(3);
    endtask

    task automatic drive_seg(input seg_t s);
        int k;
        int hi;
        octave = 3'(s.oct);
        if (s.note == 7) begin
            key = '0;
        end else begin
            k   = 1 << s.note;
            hi  = int'($urandom) & ~((k << 1) - 1) & 'h7f;
            key = 7'(k | hi);
        end
        cyc(s.dur);
    endtask

    // Plays the plan; segment D equals the hold time except a note still held when en drops.
    task automatic run_plan(input bit end_held);
        bit rec;
        int pn;
        int po;
        int pd;
        rec = 1'b0;
        pn  = 7;
        po  = 0;
        pd  = 0;
        for (int i = 0; i < plan.size(); i++) begin
            if (rec) model_seg(pn, po, pd, cyc_cnt + SYNC_LAT);
            rec = rec || (plan[i].note != 7);
            pn  = plan[i].note;
            po  = plan[i].oct;
            pd  = plan[i].dur;
            drive_seg(plan[i]);
        end
        if (rec && end_held && pn != 7) begin
            model_seg(pn, po, pd - SYNC_LAT, cyc_cnt);
            en = 1'b0;
        end else begin
            if (rec && pn != 7) begin
                model_seg(pn, po, pd, cyc_cnt + SYNC_LAT);
                key = '0;
                cyc(TAIL);
            end
            en = 1'b0;
        end
        cyc(30);
    endtask

    task automatic verify(input string tag);
        int n;
        check({tag, "_nwr"}, 32'(got_data_q.size()), 32'(exp_data_q.size()));
        n = (got_data_q.size() < exp_data_q.size()) ? got_data_q.size() : exp_data_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_addr_q[i]), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(got_data_q[i]), 32'(exp_data_q[i]));
            check($sformatf("%s_lat%0d", tag, i), 32'(got_cyc_q[i]), 32'(exp_cyc_q[i]));
        end
        check({tag, "_count"}, 32'(count), 32'(exp_data_q.size()));
        check({tag, "_full"}, 32'(full), 32'(exp_data_q.size() == int'(DEPTH)));
        check({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    task automatic add(input int note, input int oct, input int dur);
        seg_t s;
        s.note = note;
        s.oct  = oct;
        s.dur  = dur;
        plan.push_back(s);
    endtask

    initial begin
        #2;
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_addr", 32'(wr_addr), 32'(0));
        check("rst_data", 32'(wr_data), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Note, rest, note with a trailing release.
        start_session(1);
        plan.delete();
        add(2, 3, 160); add(7, 3, 80); add(4, 3, 640);
        run_plan(1'b0);
        verify("t1");
        check("t1_e0", 32'(got_at(0)), 32'(210));
        check("t1_e1", 32'(got_at(1)), 32'(251));
        check("t1_e2", 32'(got_at(2)), 32'(224));

        // Too-short first segment is discarded, long one clamps to L=0.
        start_session(1);
        plan.delete();
        add(1, 5, 5); add(3, 5, 2000);
        run_plan(1'b0);
        verify("t2");
        check("t2_e0", 32'(got_at(0)), 32'((5 << 6) | (3 << 3)));

        // Direct key-to-key change, no rest between.
        start_session(1);
        plan.delete();
        add(2, 1, 320); add(5, 2, 320);
        run_plan(1'b0);
        verify("t3");

        // full_note = 0: nothing recorded, count cleared from the previous session.
        start_session(0);
        check("t4_count_clr", 32'(count), 32'(0));
        plan.delete();
        add(3, 1, 100); add(7, 1, 100); add(6, 1, 100);
        run_plan(1'b1);
        clear_logs();
        verify("t4");

        // Memory fills at DEPTH entries; later segments are dropped.
        start_session(1);
        plan.delete();
        for (int i = 0; i < 6; i++) begin
            add(i, i, 160);
            add(7, i, 160);
        end
        run_plan(1'b0);
        verify("t5");

        // Reset in the middle of a held note.
        start_session(1);
        plan.delete();
        add(2, 4, 160); add(7, 4, 80);
        foreach (plan[i]) drive_seg(plan[i]);
        octave = 3'd4;
        key    = 7'b1000000;
        cyc(150);
        check("t6_count_pre", 32'(count), 32'(2));
        clear_logs();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_count", 32'(count), 32'(0));
        check("t6_full", 32'(full), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_wr_en", 32'(wr_en), 32'(0));
        en = 1'b0;
        cyc(20);
        rst_n = 1'b1;
        cyc(200);
        check("t6_nwr", 32'(got_data_q.size()), 32'(0));
        check("t6_count_post", 32'(count), 32'(0));

        // Random sessions.
        for (int s = 0; s < 6; s++) begin
            int prev;
            int nseg;
            int note;
            start_session(int'($urandom_range(1, 3)));
            plan.delete();
            prev = -1;
            nseg = int'($urandom_range(3, 7));
            for (int k = 0; k < nseg; k++) begin
                do note = int'($urandom_range(0, 7)); while (note == prev);
                prev = note;
                add(note, int'($urandom_range(0, 7)), int'($urandom_range(12, 700)));
            end
            run_plan(1'($urandom_range(0, 1)));
            verify($sformatf("rnd%0d", s));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
